// File: rtl/game_state_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_state_ctl                                                |
// | Purpose  : Game-level controller for a tile-uncovering puzzle game.      |
// |            Tracks IDLE / PLAYING / LOST / WON, counts uncovered safe     |
// |            tiles against the level target, and keeps an elapsed-seconds  |
// |            timer derived from the per-frame tick.                        |
// | Ports    : clk            - pixel clock, rising edge                     |
// |            rst            - synchronous active-high reset                |
// |            start          - pulse, begins a game (IDLE only)             |
// |            restart        - pulse, abandons any state back to IDLE       |
// |            frame_tick     - pulse, one per video frame                   |
// |            safe_cells     - non-mine tile count, sampled on start        |
// |            tile_reveal    - pulse per newly uncovered tile               |
// |            reveal_is_mine - qualifies tile_reveal (1 = mine)             |
// |            playing        - high in PLAYING                              |
// |            game_over      - loss indication for the text overlay         |
// |            game_won       - win indication for the text overlay          |
// |            revealed_cnt   - safe tiles uncovered this game               |
// |            elapsed_sec    - whole seconds spent in PLAYING               |
// | Options  : GAME_OVER_BLINK_EN - when defined, game_over blinks in LOST,  |
// |            toggling every 32 frame ticks; otherwise it is steady high.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module game_state_ctl #(
   parameter int SAFE_W         = 10,
   parameter int FRAMES_PER_SEC = 60,
   parameter int TIME_MAX       = 999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              restart,
   input  logic              frame_tick,
   input  logic [SAFE_W-1:0] safe_cells,
   input  logic              tile_reveal,
   input  logic              reveal_is_mine,
   output logic              playing,
   output logic              game_over,
   output logic              game_won,
   output logic [SAFE_W-1:0] revealed_cnt,
   output logic [9:0]        elapsed_sec
);

   localparam int c_div_w = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_LOST    = 2'd2,
      ST_WON     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [SAFE_W-1:0]   target_q, target_d;
   logic [SAFE_W-1:0]   revealed_cnt_q, revealed_cnt_d;
   logic [9:0]          elapsed_sec_q, elapsed_sec_d;
   logic [c_div_w-1:0]  frame_div_q, frame_div_d;
   logic                playing_q, playing_d;
   logic                game_over_q, game_over_d;
   logic                game_won_q, game_won_d;
`ifdef GAME_OVER_BLINK_EN
   logic [4:0]          blink_cnt_q, blink_cnt_d;
`endif

   always_comb begin
      state_d        = state_q;
      target_d       = target_q;
      revealed_cnt_d = revealed_cnt_q;
      elapsed_sec_d  = elapsed_sec_q;
      frame_div_d    = frame_div_q;
      playing_d      = playing_q;
      game_over_d    = game_over_q;
      game_won_d     = game_won_q;
`ifdef GAME_OVER_BLINK_EN
      blink_cnt_d    = blink_cnt_q;
`endif

      if (restart) begin
         // Restart wins over every other same-cycle event.
         state_d        = ST_IDLE;
         target_d       = '0;
         revealed_cnt_d = '0;
         elapsed_sec_d  = '0;
         frame_div_d    = '0;
         playing_d      = 1'b0;
         game_over_d    = 1'b0;
         game_won_d     = 1'b0;
`ifdef GAME_OVER_BLINK_EN
         blink_cnt_d    = '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  target_d       = safe_cells;
                  revealed_cnt_d = '0;
                  elapsed_sec_d  = '0;
                  frame_div_d    = '0;
                  // A level with no safe tiles is won immediately.
                  if (safe_cells == '0) begin
                     state_d    = ST_WON;
                     game_won_d = 1'b1;
                  end else begin
                     state_d   = ST_PLAYING;
                     playing_d = 1'b1;
                  end
               end
            end

            ST_PLAYING: begin
               // Timer and reveal are independent; both act in the same cycle.
               if (frame_tick) begin
                  if (frame_div_q == c_div_w'(FRAMES_PER_SEC - 1)) begin
                     frame_div_d = '0;
                     if (elapsed_sec_q < 10'(TIME_MAX))
                        elapsed_sec_d = elapsed_sec_q + 10'd1;
                  end else begin
                     frame_div_d = frame_div_q + c_div_w'(1);
                  end
               end
               if (tile_reveal) begin
                  if (reveal_is_mine) begin
                     state_d     = ST_LOST;
                     playing_d   = 1'b0;
                     game_over_d = 1'b1;
`ifdef GAME_OVER_BLINK_EN
                     blink_cnt_d = '0;
`endif
                  end else if (revealed_cnt_q < target_q) begin
                     revealed_cnt_d = revealed_cnt_q + SAFE_W'(1);
                     if (revealed_cnt_q + SAFE_W'(1) == target_q) begin
                        state_d    = ST_WON;
                        playing_d  = 1'b0;
                        game_won_d = 1'b1;
                     end
                  end
               end
            end

            ST_LOST: begin
`ifdef GAME_OVER_BLINK_EN
               // The 32nd tick of each period flips the overlay text.
               if (frame_tick) begin
                  blink_cnt_d = blink_cnt_q + 5'd1;
                  if (blink_cnt_q == 5'd31)
                     game_over_d = ~game_over_q;
               end
`endif
            end

            ST_WON: begin
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         target_q       <= '0;
         revealed_cnt_q <= '0;
         elapsed_sec_q  <= '0;
         frame_div_q    <= '0;
         playing_q      <= 1'b0;
         game_over_q    <= 1'b0;
         game_won_q     <= 1'b0;
`ifdef GAME_OVER_BLINK_EN
         blink_cnt_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         revealed_cnt_q <= revealed_cnt_d;
         elapsed_sec_q  <= elapsed_sec_d;
         frame_div_q    <= frame_div_d;
         playing_q      <= playing_d;
         game_over_q    <= game_over_d;
         game_won_q     <= game_won_d;
`ifdef GAME_OVER_BLINK_EN
         blink_cnt_q    <= blink_cnt_d;
`endif
      end
   end

   assign playing      = playing_q;
   assign game_over    = game_over_q;
   assign game_won     = game_won_q;
   assign revealed_cnt = revealed_cnt_q;
   assign elapsed_sec  = elapsed_sec_q;

endmodule
`default_nettype wire

// File: doc/game_state_ctl.md
GAME_STATE_CTL -- requirements
Module: game_state_ctl

Interface
REQ-001 Parameter SAFE_W, 10, width of the safe-cell count and the revealed-cell counter.
REQ-002 Parameter FRAMES_PER_SEC, 60, number of frame_tick pulses per elapsed second.
REQ-003 Parameter TIME_MAX, 999, saturation value of the seconds counter.
REQ-004 Port clk  input  1  system pixel clock; all logic is clocked on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  one-cycle pulse that begins a game.
REQ-007 Port restart  input  1  one-cycle pulse that abandons any state and returns to IDLE.
REQ-008 Port frame_tick  input  1  one-cycle pulse, one per VGA frame.
REQ-009 Port safe_cells  input  SAFE_W  number of non-mine tiles for the current level; sampled on start.
REQ-010 Port tile_reveal  input  1  one-cycle pulse per newly uncovered tile.
REQ-011 Port reveal_is_mine  input  1  qualifies tile_reveal; high means the uncovered tile is a mine.
REQ-012 Port playing  output  1  high in PLAYING.
REQ-013 Port game_over  output  1  loss indication that feeds the end-of-game text overlay.
REQ-014 Port game_won  output  1  win indication that feeds the end-of-game text overlay.
REQ-015 Port revealed_cnt  output  SAFE_W  safe tiles uncovered in the current game.
REQ-016 Port elapsed_sec  output  10  whole seconds spent in PLAYING.

Function
REQ-017 FSM states SHALL be IDLE, PLAYING, LOST and WON; every output is registered.
REQ-018 From IDLE, start SHALL enter PLAYING, latch safe_cells into target, and clear revealed_cnt, elapsed_sec and the frame divider.
REQ-019 If the latched target is 0 on start, the FSM SHALL enter WON instead of PLAYING.
REQ-020 In PLAYING, tile_reveal with reveal_is_mine=1 SHALL enter LOST; game_over rises on the cycle after the pulse.
REQ-021 In PLAYING, tile_reveal with reveal_is_mine=0 SHALL increment revealed_cnt.
REQ-022 When that increment makes revealed_cnt equal target, the FSM SHALL enter WON in the same edge; game_won rises on the cycle after the pulse.
REQ-023 revealed_cnt SHALL NOT exceed target.
REQ-024 tile_reveal outside PLAYING SHALL be ignored.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 The frame divider SHALL count frame_tick pulses only in PLAYING; on reaching FRAMES_PER_SEC-1 it wraps to 0 and increments elapsed_sec.
REQ-027 elapsed_sec SHALL saturate at TIME_MAX.
REQ-028 elapsed_sec and revealed_cnt SHALL hold their values in LOST and WON.
REQ-029 restart SHALL return the FSM to IDLE from any state and clear all counters and outputs on the next edge.
REQ-030 restart SHALL take priority over start, tile_reveal and frame_tick when they occur in the same cycle.
REQ-031 When tile_reveal and frame_tick occur in the same cycle, both SHALL take effect in that cycle.
REQ-032 game_over and game_won SHALL never be high simultaneously.

Reset
REQ-033 On rst the FSM SHALL go to IDLE and every output, the target register and the frame divider SHALL be 0.
REQ-034 rst asserted mid-game SHALL abort the game with no residual outputs on the cycle after rst.

Configuration
REQ-035 With GAME_OVER_BLINK_EN defined, game_over in LOST SHALL toggle after every 32 frame_tick pulses, starting high on LOST entry, so the end-of-game text blinks.
REQ-036 Without GAME_OVER_BLINK_EN, game_over SHALL be steady high for the whole of LOST and the blink counter SHALL not be synthesised.
REQ-037 game_won SHALL be steady high in WON in both builds.

Verification
REQ-038 Win path: safe_cells=3, start, then 3 safe reveals -> game_won=1 one cycle after the 3rd reveal, revealed_cnt=3, game_over=0.
REQ-039 Mine hit: safe_cells=10, start, 2 safe reveals, then a mine reveal -> game_over=1 next cycle, revealed_cnt=2; further reveals leave it at 2.
REQ-040 Timer: FRAMES_PER_SEC=60, PLAYING for 150 frame_ticks -> elapsed_sec=2; 60000 frame_ticks -> elapsed_sec=999 (saturated).
REQ-041 Same-cycle conflict: in PLAYING, restart together with a mine reveal -> state IDLE, game_over=0, all counters 0.
REQ-042 Blink build: in LOST, 32 frame_ticks -> game_over=0; 64 frame_ticks -> game_over=1; non-blink build -> game_over stays 1 throughout.
REQ-043 Zero target: safe_cells=0, start -> game_won=1 next cycle, playing=0.
